// File: rtl/xevious_pkg.sv
// Shared types and defaults for the Xevious ROM download path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package xevious_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } loader_state_t;

  // Exact byte count of a valid Xevious ROM image
  localparam int ROM_SIZE_DEF = 'h1C000;

  // Cycles the core stays in reset after a good load completes
  localparam int HOLD_CYCLES_DEF = 16;

endpackage : xevious_pkg

// File: rtl/xevious_rom_loader.sv
// Streams the ioctl ROM download into the core, checks size/order, and holds core reset until a good image is in.
// Latency: one clk_sys cycle from an accepted ioctl_wr to the matching dn_wr pulse.
// Backpressure: none; ioctl bytes are accepted or dropped in the cycle they arrive.
module xevious_rom_loader
  import xevious_pkg::*;
#(
  parameter int ROM_SIZE    = ROM_SIZE_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_hold,
  output logic        rom_ready,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [15:0] checksum
);

  // Settle counter only needs to reach HOLD_CYCLES-1
  localparam int SETTLE_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(HOLD_CYCLES - 1);
  localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [16:0] ROM_BYTES = 17'(ROM_SIZE);

  loader_state_t        state_q;
  loader_state_t        state_d;
  logic                 download_q;
  logic                 ovf_q;
  logic                 seq_q;
  logic [SETTLE_W-1:0]  settle_q;

  logic                 dl_rise;
  logic                 dl_fall;
  logic                 in_load;
  logic                 addr_in_range;
  logic                 addr_in_seq;
  logic                 byte_acc;
  logic                 ovf_hit;
  logic                 seq_hit;
  logic [16:0]          count_next;
  logic                 load_good;
  logic                 start_load;

  // Download edges come from a one-cycle delayed copy of ioctl_download
  assign dl_rise = ioctl_download & ~download_q;
  assign dl_fall = ~ioctl_download & download_q;

  // Byte classification; only meaningful (and only acted on) while loading
  assign in_load       = (state_q == ST_LOAD);
  assign addr_in_range = (ioctl_addr < ROM_LIMIT);
  assign addr_in_seq   = (ioctl_addr == {8'd0, byte_count});
  assign byte_acc      = in_load & ioctl_wr & addr_in_range & addr_in_seq;
  assign ovf_hit       = in_load & ioctl_wr & ~addr_in_range;
  assign seq_hit       = in_load & ioctl_wr & ~addr_in_seq;

  // End-of-load verdict includes a byte arriving on the same cycle as the falling edge
  assign count_next = byte_count + {16'd0, byte_acc};
  assign load_good  = (count_next == ROM_BYTES) & ~(ovf_q | ovf_hit | seq_q | seq_hit);

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic and load-start strobe
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (dl_fall) begin
          state_d = load_good ? ST_SETTLE : ST_ERR;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Delayed download copy; resets high so a download already active at reset release is not an edge
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      download_q <= 1'b1;
    end else begin
      download_q <= ioctl_download;
    end
  end

  // Byte counter, running checksum and the sticky overflow/sequence flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      byte_count <= 17'd0;
      checksum   <= 16'd0;
      ovf_q      <= 1'b0;
      seq_q      <= 1'b0;
    end else if (start_load) begin
      byte_count <= 17'd0;
      checksum   <= 16'd0;
      ovf_q      <= 1'b0;
      seq_q      <= 1'b0;
    end else begin
      if (byte_acc) begin
        byte_count <= count_next;
        checksum   <= checksum + {8'd0, ioctl_dout};
      end
      if (ovf_hit) begin
        ovf_q <= 1'b1;
      end
      if (seq_hit) begin
        seq_q <= 1'b1;
      end
    end
  end

  // Core write port: one-cycle strobe, address/data held between writes
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dn_wr   <= 1'b0;
      dn_addr <= 17'd0;
      dn_data <= 8'd0;
    end else begin
      dn_wr <= byte_acc;
      if (byte_acc) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
    end
  end

  // Settle counter runs only while in SETTLE and restarts from zero on entry
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
    end else if (state_q == ST_SETTLE) begin
      settle_q <= settle_q + 1'b1;
    end else begin
      settle_q <= '0;
    end
  end

  // Registered status outputs, decoded from the next state so they switch with it
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      core_hold <= 1'b1;
      rom_ready <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      core_hold <= (state_d != ST_DONE);
      rom_ready <= (state_d == ST_DONE);
      load_err  <= (state_d == ST_ERR);
    end
  end

endmodule : xevious_rom_loader

// File: doc/xevious_rom_loader.md
XEVIOUS_ROM_LOADER -- requirements
Module: xevious_rom_loader

Interface
REQ-001 Parameter ROM_SIZE, default 17'h1C000, the exact byte count of a valid ROM image.
REQ-002 Parameter HOLD_CYCLES, default 16, the number of clk_sys cycles core_hold stays high after a successful load.
REQ-003 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_download  in  1  high for the whole ROM download.
REQ-006 ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-007 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 dn_addr  out  17  ROM write address to the core.
REQ-010 dn_data  out  8  ROM write data to the core.
REQ-011 dn_wr  out  1  one-cycle ROM write strobe to the core.
REQ-012 core_hold  out  1  high holds the game core in reset; ORed into the core reset by the parent.
REQ-013 rom_ready  out  1  high when the last load completed without error.
REQ-014 load_err  out  1  high when the last load failed.
REQ-015 byte_count  out  17  number of bytes accepted in the current or last load.
REQ-016 checksum  out  16  sum modulo 2^16 of the accepted bytes.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, SETTLE, DONE and ERR.
REQ-018 From IDLE, DONE or ERR, a rising edge of ioctl_download SHALL enter LOAD and, in the same edge, clear byte_count, checksum, rom_ready and load_err.
REQ-019 In LOAD, each ioctl_wr with ioctl_addr < ROM_SIZE and ioctl_addr == byte_count SHALL, one cycle later, drive dn_addr = ioctl_addr[16:0], dn_data = ioctl_dout and dn_wr = 1 for exactly one cycle.
REQ-020 That same accepted byte SHALL increment byte_count and add the zero-extended byte to checksum, both updating on the same edge that raises dn_wr.
REQ-021 In LOAD, an ioctl_wr with ioctl_addr >= ROM_SIZE SHALL be dropped (no dn_wr) and SHALL latch an internal overflow flag.
REQ-022 In LOAD, an ioctl_wr with ioctl_addr != byte_count SHALL be dropped and SHALL latch an internal sequence flag.
REQ-023 A falling edge of ioctl_download in LOAD SHALL go to SETTLE when byte_count == ROM_SIZE and neither flag is set; otherwise it SHALL go to ERR.
REQ-024 If ioctl_wr coincides with the falling edge of ioctl_download, that byte SHALL be processed per REQ-019..022 before the end-of-load decision.
REQ-025 SETTLE SHALL count HOLD_CYCLES cycles and then enter DONE with rom_ready = 1.
REQ-026 ERR SHALL set load_err = 1 and SHALL hold core_hold = 1.
REQ-027 core_hold SHALL be 1 in every state except DONE.
REQ-028 ioctl_wr outside LOAD SHALL be ignored.
REQ-029 dn_addr and dn_data SHALL hold their last values while dn_wr = 0.

Reset
REQ-030 While reset is asserted, the block SHALL be in IDLE with dn_wr = 0, dn_addr = 0, dn_data = 0, core_hold = 1, rom_ready = 0, load_err = 0, byte_count = 0 and checksum = 0, and with both flags and the SETTLE counter cleared.
REQ-031 A reset during LOAD or SETTLE SHALL abandon the load; after reset is released, a new rising edge of ioctl_download is required to start a load.
REQ-032 If ioctl_download is already high when reset is released, that SHALL NOT count as a rising edge.

Structure
REQ-033 A shared package xevious_pkg SHALL hold the state enum type, the ROM_SIZE default and the HOLD_CYCLES default.
REQ-034 The block SHALL be a single module with no sub-modules; edge detection SHALL use a one-cycle delayed copy of ioctl_download.

Verification
REQ-035 Load bytes 0..ROM_SIZE-1 with data = addr[7:0], then drop ioctl_download -> ROM_SIZE dn_wr pulses, each one cycle after its ioctl_wr; byte_count = 17'h1C000; checksum = expected modulo sum; core_hold falls 16 cycles after SETTLE is entered; rom_ready = 1.
REQ-036 Load only ROM_SIZE-1 bytes -> load_err = 1, rom_ready = 0, core_hold stays 1.
REQ-037 Write ioctl_addr = 17'h1C000 during a load -> no dn_wr for that byte; ERR at end of download.
REQ-038 Skip address 5 (write 4 then 6) -> byte at 6 dropped, byte_count = 5, ERR at end.
REQ-039 Assert reset mid-load at byte 100, release it, then run a full load -> outputs hold reset values until the new rising edge; the full load ends in DONE.
REQ-040 Final byte's ioctl_wr on the same cycle as the ioctl_download falling edge -> byte written, byte_count = ROM_SIZE, DONE reached.
